// File: rtl/bank_cache_ctrl_pkg.sv
// bank_cache_ctrl_pkg: shared constants, FSM encoding and slot helpers for the bank cache controller
package bank_cache_ctrl_pkg;
  localparam int SLOTS = 4;
  localparam int BANK_W = 4;
  localparam int SLOT_W = 2;
  typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_WAIT, RESP} state_t;
  // lowest set bit of a slot mask; callers guarantee at least one bit is set when the result matters
  function automatic logic [SLOT_W-1:0] low_idx(input logic [SLOTS-1:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/bank_cache_ctrl_if.sv
// bank_cache_ctrl_if: request/response/refill handshakes plus resident tag view
// slave modport = controller side, master modport = requester/refill side
interface bank_cache_ctrl_if;
  import bank_cache_ctrl_pkg::*;
  logic req_valid, req_ready;
  logic [BANK_W-1:0] req_bank_0, req_bank_1;
  logic resp_valid, resp_ready;
  logic [SLOT_W-1:0] resp_slot_0, resp_slot_1;
  logic fill_valid, fill_ready, fill_done;
  logic [BANK_W-1:0] fill_bank;
  logic [SLOT_W-1:0] fill_slot;
  logic [SLOTS*BANK_W-1:0] base_bank;
  logic [SLOTS-1:0] base_vld;
  modport slave(
    input req_valid, req_bank_0, req_bank_1, resp_ready, fill_ready, fill_done,
    output req_ready, resp_valid, resp_slot_0, resp_slot_1, fill_valid, fill_bank, fill_slot, base_bank, base_vld
  );
  modport master(
    output req_valid, req_bank_0, req_bank_1, resp_ready, fill_ready, fill_done,
    input req_ready, resp_valid, resp_slot_0, resp_slot_1, fill_valid, fill_bank, fill_slot, base_bank, base_vld
  );
endinterface

// File: rtl/bank_mlru.sv
// bank_mlru: pseudo-LRU access bits and victim choice
// ports: clk, rst_n, upd (apply access), used (slots touched by this request), vld_nxt (slot valid after this cycle), victim
module bank_mlru
  import bank_cache_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd,
  input  logic [SLOTS-1:0]  used,
  input  logic [SLOTS-1:0]  vld_nxt,
  output logic [SLOT_W-1:0] victim
);
  logic [SLOTS-1:0] mbit, merged, mbit_nxt;
  assign merged = mbit | used;
  // saturation keeps only the current request's slots so a zero bit always remains
  assign mbit_nxt = &merged ? used : merged;
  // victim is chosen from post-update state, so slots touched by this request are never picked
  assign victim = &vld_nxt ? low_idx(~mbit_nxt) : low_idx(~vld_nxt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mbit <= '0;
    else if (upd) mbit <= mbit_nxt;
endmodule

// File: rtl/bank_cache_ctrl.sv
// bank_cache_ctrl: maps a pair of bank IDs onto resident slots, refilling misses into pseudo-LRU victims
// ports: clk, rst_n (async, active low), bus (slave modport: request, response, refill, tag view)
module bank_cache_ctrl
  import bank_cache_ctrl_pkg::*;
#(
  parameter int NSLOT = SLOTS
) (
  input logic clk,
  input logic rst_n,
  bank_cache_ctrl_if.slave bus
);
  state_t st;
  logic lk, cur, need1, rdy, rv, fv, upd, done;
  logic [BANK_W-1:0] b0, b1, fb;
  logic [SLOT_W-1:0] rs0, rs1, fs, victim;
  logic [NSLOT-1:0] vld, hm0, hm1, acc, cmp0, cmp1, fmask, used, vld_nxt;
  logic [NSLOT*BANK_W-1:0] tags;
  for (genvar i = 0; i < NSLOT; i++) begin : g_cmp
    assign cmp0[i] = vld[i] && tags[i*BANK_W +: BANK_W] == b0;
    assign cmp1[i] = vld[i] && tags[i*BANK_W +: BANK_W] == b1;
  end
  assign done = st == FILL_WAIT && bus.fill_done;
  assign fmask = NSLOT'(1) << fs;
  assign upd = (st == LOOKUP && lk) || done;
  assign used = done ? acc | fmask : hm0 | hm1;
  assign vld_nxt = done ? vld | fmask : vld;
  bank_mlru u_mlru (.clk(clk), .rst_n(rst_n), .upd(upd), .used(used), .vld_nxt(vld_nxt), .victim(victim));
  // LOOKUP spends one cycle registering the tag compares (lk=0) and one cycle acting on them (lk=1)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      {lk, cur, need1, rv, fv} <= '0;
      rdy <= 1'b1;
      {b0, b1, fb, rs0, rs1, fs} <= '0;
      {vld, hm0, hm1, acc} <= '0;
      tags <= '0;
    end else
      case (st)
        IDLE: if (bus.req_valid) begin
          b0 <= bus.req_bank_0;
          b1 <= bus.req_bank_1;
          rdy <= 1'b0;
          lk <= 1'b0;
          st <= LOOKUP;
        end
        LOOKUP: if (!lk) begin
          hm0 <= cmp0;
          hm1 <= cmp1;
          lk <= 1'b1;
        end else begin
          lk <= 1'b0;
          acc <= hm0 | hm1;
          rs0 <= low_idx(hm0);
          rs1 <= low_idx(hm1);
          if (|hm0 && |hm1) begin
            rv <= 1'b1;
            st <= RESP;
          end else begin
            cur <= |hm0;
            fb <= |hm0 ? b1 : b0;
            fs <= victim;
            need1 <= !(|hm0) && !(|hm1) && b0 != b1;
            fv <= 1'b1;
            st <= FILL_REQ;
          end
        end
        FILL_REQ: if (bus.fill_ready) begin
          fv <= 1'b0;
          st <= FILL_WAIT;
        end
        FILL_WAIT: if (bus.fill_done) begin
          tags[fs*BANK_W +: BANK_W] <= fb;
          vld <= vld_nxt;
          acc <= used;
          if (!cur) rs0 <= fs;
          if (cur || b0 == b1) rs1 <= fs;
          if (need1) begin
            need1 <= 1'b0;
            cur <= 1'b1;
            fb <= b1;
            fs <= victim;
            fv <= 1'b1;
            st <= FILL_REQ;
          end else begin
            rv <= 1'b1;
            st <= RESP;
          end
        end
        RESP: if (bus.resp_ready) begin
          rv <= 1'b0;
          rdy <= 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
  assign bus.req_ready = rdy;
  assign bus.resp_valid = rv;
  assign bus.resp_slot_0 = rs0;
  assign bus.resp_slot_1 = rs1;
  assign bus.fill_valid = fv;
  assign bus.fill_bank = fb;
  assign bus.fill_slot = fs;
  assign bus.base_bank = tags;
  assign bus.base_vld = vld;
endmodule

// File: tb/tb_bank_cache_ctrl.sv
// tb_bank_cache_ctrl: scoreboard bench with a slot-table reference model and randomized requests
module tb_bank_cache_ctrl;
  import bank_cache_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  bank_cache_ctrl_if bus();
  bank_cache_ctrl #(.NSLOT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {logic [1:0] s0, s1; logic [3:0] vld; logic [15:0] tags;} resp_t;
  logic [5:0] fill_q[$];
  resp_t resp_q[$];
  int errors = 0, checks = 0;
  logic [3:0] mtag[4];
  logic [3:0] mvld, mm;
  logic stall = 1'b0, stray = 1'b0, hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout/absent required=event", name);
  endtask

  function automatic logic [3:0] touch(input logic [3:0] m, input logic [3:0] u);
    logic [3:0] n;
    n = m | u;
    return (n == 4'hf) ? u : n;
  endfunction

  function automatic int pick();
    for (int k = 0; k < 4; k++) if (!mvld[k]) return k;
    for (int k = 0; k < 4; k++) if (!mm[k]) return k;
    return 0;
  endfunction

  function automatic logic [3:0] miss_bank();
    for (int b = 0; b < 16; b++) begin
      bit hit = 0;
      for (int k = 0; k < 4; k++) if (mvld[k] && mtag[k] == 4'(b)) hit = 1;
      if (!hit) return 4'(b);
    end
    return 4'd0;
  endfunction

  // reference: look up both banks, touch hits, then fill each missing bank into the chosen victim
  task automatic model_req(input logic [3:0] a, input logic [3:0] b, output bit allhit);
    logic [3:0] used;
    int s0, s1, v;
    used = 4'd0; s0 = -1; s1 = -1;
    for (int k = 0; k < 4; k++) begin
      if (mvld[k] && mtag[k] == a) s0 = k;
      if (mvld[k] && mtag[k] == b) s1 = k;
    end
    allhit = s0 >= 0 && s1 >= 0;
    if (s0 >= 0) used[s0] = 1'b1;
    if (s1 >= 0) used[s1] = 1'b1;
    mm = touch(mm, used);
    if (s0 < 0) begin
      v = pick();
      fill_q.push_back({a, 2'(v)});
      mtag[v] = a; mvld[v] = 1'b1; used[v] = 1'b1;
      mm = touch(mm, used);
      s0 = v;
      if (a == b) s1 = v;
    end
    if (s1 < 0) begin
      v = pick();
      fill_q.push_back({b, 2'(v)});
      mtag[v] = b; mvld[v] = 1'b1; used[v] = 1'b1;
      mm = touch(mm, used);
      s1 = v;
    end
    resp_q.push_back({2'(s0), 2'(s1), mvld, {mtag[3], mtag[2], mtag[1], mtag[0]}});
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_bank_0 = a; bus.req_bank_1 = b;
    while (!bus.req_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) fail_now("req_accept");
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic do_req(input logic [3:0] a, input logic [3:0] b);
    bit ah;
    model_req(a, b, ah);
    issue(a, b);
    if (ah) begin
      @(posedge clk); @(negedge clk);
      chk("hit_latency_n1", 32'(bus.resp_valid), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("hit_latency_n2", 32'(bus.resp_valid), 32'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((fill_q.size() != 0 || resp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) fail_now("drain");
    repeat (2) @(negedge clk);
  endtask

  // refill engine: random ready, completes each accepted fill a few cycles later
  initial begin
    int pend = 0;
    logic [5:0] e;
    bus.fill_ready = 1'b0; bus.fill_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 0;
      bus.fill_done = stray || pend == 1;
      if (pend > 0) pend--;
      bus.fill_ready = !stall && $urandom_range(0, 1) == 1;
      if (bus.fill_valid && bus.fill_ready && rst_n) begin
        if (hold) pend = 0;
        else begin
          if (fill_q.size() == 0) fail_now("fill_unexpected");
          else begin
            e = fill_q.pop_front();
            chk("fill_cmd", 32'({bus.fill_bank, bus.fill_slot}), 32'(e));
          end
          pend = $urandom_range(1, 3);
        end
      end
    end
  end

  // response monitor
  initial begin
    resp_t r;
    bus.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.resp_ready = $urandom_range(0, 3) != 0;
      if (bus.resp_valid && bus.resp_ready && rst_n) begin
        if (resp_q.size() == 0) fail_now("resp_unexpected");
        else begin
          r = resp_q.pop_front();
          chk("resp_slots", 32'({bus.resp_slot_0, bus.resp_slot_1}), 32'({r.s0, r.s1}));
          chk("base_vld", 32'(bus.base_vld), 32'(r.vld));
          chk("base_bank", 32'(bus.base_bank), 32'(r.tags));
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_fill_valid"}, 32'(bus.fill_valid), 32'd0);
    chk({tag, "_base_vld"}, 32'(bus.base_vld), 32'd0);
    chk({tag, "_base_bank"}, 32'(bus.base_bank), 32'd0);
    chk({tag, "_resp_slots"}, 32'({bus.resp_slot_0, bus.resp_slot_1}), 32'd0);
    chk({tag, "_fill_cmd"}, 32'({bus.fill_bank, bus.fill_slot}), 32'd0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mtag[k] = 4'd0;
    mvld = 4'd0; mm = 4'd0;
  endtask

  initial begin
    logic [3:0] a, b, fb0, pre;
    logic [1:0] fs0;
    int n;
    bus.req_valid = 1'b0; bus.req_bank_0 = 4'd0; bus.req_bank_1 = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks("init");
    rst_n = 1'b1;
    #1 chk("req_ready_after_reset", 32'(bus.req_ready), 32'd1);
    // directed: cold fill, all-hit latency, fills into free slots, duplicate bank, mixed hit/miss
    do_req(4'd3, 4'd5);
    do_req(4'd3, 4'd5);
    do_req(4'd4, 4'd6);
    do_req(4'd2, 4'd4);
    do_req(4'd7, 4'd7);
    do_req(4'd5, 4'd9);
    do_req(4'd9, 4'd5);
    drain();
    // refill stall with a stray fill_done while the command is pending
    pre = mvld;
    stall = 1'b1;
    a = miss_bank();
    do_req(a, a);
    n = 0;
    while (!bus.fill_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail_now("stall_fill_valid");
    fb0 = bus.fill_bank; fs0 = bus.fill_slot;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      stray = (i == 1);
      @(negedge clk);
      chk("stall_fill_valid", 32'(bus.fill_valid), 32'd1);
      chk("stall_fill_cmd", 32'({bus.fill_bank, bus.fill_slot}), 32'({fb0, fs0}));
      chk("stall_base_vld", 32'(bus.base_vld), 32'(pre));
    end
    stall = 1'b0;
    // randomized traffic over a small bank range so hits, misses and duplicates all occur
    for (int t = 0; t < 150; t++) begin
      a = 4'($urandom_range(0, 7));
      b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 7));
      do_req(a, b);
    end
    drain();
    // reset while waiting for fill completion
    hold = 1'b1;
    a = miss_bank();
    issue(a, a);
    n = 0;
    while (!bus.fill_valid && n < 100) begin @(negedge clk); n++; end
    while (bus.fill_valid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) fail_now("reach_fill_wait");
    rst_n = 1'b0;
    #1 reset_checks("midfill");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    #1 chk("req_ready_after_rerelease", 32'(bus.req_ready), 32'd1);
    @(posedge clk); stray = 1'b1;
    @(posedge clk); stray = 1'b0;
    @(negedge clk);
    chk("late_fill_done_vld", 32'(bus.base_vld), 32'd0);
    do_req(4'd3, 4'd5);
    do_req(4'd5, 4'd3);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bank_cache_ctrl.md
BANK_CACHE_CTRL -- requirements
Module: bank_cache_ctrl

Interface
REQ-001 The block SHALL have the parameter NSLOT, default 4, meaning the number of resident bank slots; only 4 is supported.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have the port req_valid, input, 1 bit: a lookup request is present.
REQ-005 The block SHALL have the port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have the ports req_bank_0 and req_bank_1, input, 4 bits each: the two bank IDs requested together.
REQ-007 The block SHALL have the port resp_valid, output, 1 bit: slot indices are valid.
REQ-008 The block SHALL have the port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-009 The block SHALL have the ports resp_slot_0 and resp_slot_1, output, 2 bits each: the slots holding req_bank_0 and req_bank_1.
REQ-010 The block SHALL have the port fill_valid, output, 1 bit: a refill command is pending.
REQ-011 The block SHALL have the port fill_ready, input, 1 bit: the refill engine accepts the command.
REQ-012 The block SHALL have the port fill_bank, output, 4 bits: the bank to load.
REQ-013 The block SHALL have the port fill_slot, output, 2 bits: the destination slot.
REQ-014 The block SHALL have the port fill_done, input, 1 bit: a single-cycle pulse meaning the refill is complete.
REQ-015 The block SHALL have the port base_bank, output, 16 bits: the bank tag of slot k in bits [4k+3:4k].
REQ-016 The block SHALL have the port base_vld, output, 4 bits: per-slot valid.

Function
REQ-017 The FSM SHALL have the states IDLE, LOOKUP, FILL_REQ, FILL_WAIT and RESP, one-hot or binary.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid&req_ready at a clock edge; req_bank_0/1 are registered at acceptance.
REQ-019 In LOOKUP, the hit for bank b in slot k SHALL be base_vld[k] & (base_bank[k]==b).
- If both banks hit, the next state is RESP.
- Otherwise, the next state is FILL_REQ for the first missing bank (bank_0 before bank_1).
REQ-020 When req_bank_0==req_bank_1, the block SHALL issue at most one fill, and resp_slot_0==resp_slot_1.
REQ-021 The victim slot SHALL be the lowest-index invalid slot if any slot is invalid; otherwise it is the lowest index k with mbit[k]==0.
REQ-022 fill_valid SHALL be 1 only in FILL_REQ, with fill_bank and fill_slot held stable until fill_valid&fill_ready; the transition is then to FILL_WAIT.
REQ-023 In FILL_WAIT, on fill_done the block SHALL:
- write the tag into the slot;
- set base_vld for the slot;
- mark the slot in mbit;
- go to FILL_REQ if the other bank still misses, else to RESP.
REQ-024 fill_done outside FILL_WAIT SHALL be ignored.
REQ-025 The second fill of a request SHALL never select the slot filled by the first fill, nor the slot hit by the other bank.
REQ-026 The mbit update (4 bits) SHALL happen at LOOKUP for hit slots and at each fill_done for the filled slot.
- new = mbit | used.
- If new==4'b1111, mbit is instead set to used (current-access bits only).
REQ-027 resp_valid SHALL be 1 only in RESP, with the slots held until resp_valid&resp_ready; the transition is then to IDLE.
REQ-028 An all-hit request SHALL have latency 2 cycles: accepted at edge N, resp_valid high after edge N+2.
REQ-029 base_bank and base_vld SHALL change only on fill_done, and be registered.

Reset
REQ-030 On rst_n low, the block SHALL asynchronously set:
- state=IDLE;
- mbit=0 and base_vld=0;
- base_bank=0;
- resp_valid=0 and fill_valid=0;
- resp_slot_0/1=0 and fill_slot=0 and fill_bank=0.
REQ-031 Reset during FILL_REQ/FILL_WAIT SHALL abandon the fill; a later fill_done is ignored.
REQ-032 req_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the slot-count constant (4), the bank ID width (4) and the slot index width (2).
REQ-034 The pseudo-LRU (mbit register, update rule and victim encoder) SHALL be a sub-module named bank_mlru; the FSM and the tag array stay in the top.

Verification
REQ-035 Test: after reset, request (3,5) -> fill(3,slot0) then fill(5,slot1); resp slots (0,1); base_vld=4'b0011.
REQ-036 Test: slots hold 0,1,2,3 with mbit=0; request (2,3) -> no fill; resp (2,3) two cycles after acceptance; mbit=4'b1100.
REQ-037 Test: with mbit=4'b1100, request (0,9) -> slot 0 hits; 9 fills slot 1; mbit saturates and becomes 4'b0011.
REQ-038 Test: request (7,7) with all slots valid and mbit=4'b0001 -> exactly one fill, to slot 1; resp (1,1).
REQ-039 Test: hold fill_ready=0 for 5 cycles -> fill_valid, fill_bank and fill_slot stay stable; a stray fill_done during FILL_REQ has no effect.
REQ-040 Test: assert rst_n low in FILL_WAIT -> all outputs at reset values; a later fill_done leaves base_vld=0.
